// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Buffers ALU/load results in order, retires one per cycle, and forwards pending values to A1/A2.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_rd,
  input  logic [DW-1:0]              alu_wd,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_rd,
  input  logic [DW-1:0]              mem_wd,
  input  logic                       wb_stall,
  output logic                       WE3,
  output logic [AW-1:0]              A3,
  output logic [DW-1:0]              WD3,
  input  logic [AW-1:0]              A1,
  input  logic [AW-1:0]              A2,
  output logic                       fwd1_hit,
  output logic [DW-1:0]              fwd1_data,
  output logic                       fwd2_hit,
  output logic [DW-1:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    q_rd [DEPTH];
  logic [DW-1:0]    q_wd [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;

  logic          not_full;
  logic          mem_fire;
  logic          alu_fire;
  logic          push;
  logic          pop;
  logic [AW-1:0] enq_rd;
  logic [DW-1:0] enq_wd;
  logic [PW-1:0] idx;

  assign count = occ;

  // Memory wins arbitration; a full queue refuses even if the head retires this cycle.
  always_comb begin
    not_full  = (occ < FULL);
    mem_ready = !rst && not_full;
    alu_ready = !rst && not_full && !mem_valid;
    mem_fire  = mem_valid && mem_ready;
    alu_fire  = alu_valid && alu_ready;
    enq_rd    = mem_fire ? mem_rd : alu_rd;
    enq_wd    = mem_fire ? mem_wd : alu_wd;
    push      = (mem_fire || alu_fire) && (enq_rd != '0);
    WE3       = !rst && !wb_stall && (occ != '0);
    pop       = WE3;
    A3        = '0;
    WD3       = '0;
    if (!rst && (occ != '0)) begin
      A3  = q_rd[rd_ptr];
      WD3 = q_wd[rd_ptr];
    end
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (q_valid[idx] && (A1 != '0) && (q_rd[idx] == A1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = q_wd[idx];
        end
        if (q_valid[idx] && (A2 != '0) && (q_rd[idx] == A2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = q_wd[idx];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      q_valid <= '0;
    end else begin
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits guard it.
  always_ff @(posedge CLK) begin
    if (!rst && push) begin
      q_rd[wr_ptr] <= enq_rd;
      q_wd[wr_ptr] <= enq_wd;
    end
  end

endmodule
